pll_lock_sequencer: RTL and testbench

Sequencer and lock monitor for the digital PLL trim loop. It runs on the reference clock, owns the PLL controller's reset and divider setting, and watches the 26-bit trim code coming from the PLL clock domain. It declares lock once the trim code has stayed within a tolerance band for a number of consecutive windows, then requests the system clock switch to the PLL. It also detects loss of lock and lock timeout.

---
 rtl/pll_seq_pkg.sv | 40 ++++
 rtl/pll_lock_sequencer_if.sv | 32 +++
 rtl/trim_window_monitor.sv | 109 ++++++++++
 rtl/pll_lock_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL lock sequencer slice:
//   - pll_seq_state_t : sequencer FSM state encoding (also driven on the debug
//                       `state` output, so the numeric values are fixed)
//   - PC_W            : width of a trim popcount (0..26 fits in 5 bits)
//   - TRIM_W / DIV_W  : trim code and divider widths
//   - DEF_*           : default timing parameters for the sequencer
//   - clamp_div()     : divider load clamp (factors below 2 are not usable)
// -----------------------------------------------------------------------------
package pll_seq_pkg;

    localparam int PC_W   = 5;
    localparam int TRIM_W = 26;
    localparam int DIV_W  = 5;

    localparam int DEF_RST_CYC      = 16;
    localparam int DEF_SETTLE_CYC   = 1024;
    localparam int DEF_WIN_CYC      = 256;
    localparam int DEF_LOCK_WINS    = 4;
    localparam int DEF_TOL          = 1;
    localparam int DEF_TIMEOUT_WINS = 64;

    localparam logic [DIV_W-1:0] DIV_RESET = 5'd8;
    localparam logic [DIV_W-1:0] DIV_MIN   = 5'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RSTPLL  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAULT   = 3'd5
    } pll_seq_state_t;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer_if
// Control/status bundle of the PLL lock sequencer.
//   master (system side) drives : enable, cfg_we, div_cfg, trim
//   slave  (sequencer)   drives : pll_reset, div, lock, sel_pll, timeout, state
// `trim` originates in the PLL clock domain; the sequencer synchronizes it.
// -----------------------------------------------------------------------------
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;

    logic              enable;
    logic              cfg_we;
    logic [DIV_W-1:0]  div_cfg;
    logic [TRIM_W-1:0] trim;
    logic              pll_reset;
    logic [DIV_W-1:0]  div;
    logic              lock;
    logic              sel_pll;
    logic              timeout;
    logic [2:0]        state;

    modport master (
        output enable, cfg_we, div_cfg, trim,
        input  pll_reset, div, lock, sel_pll, timeout, state
    );

    modport slave (
        input  enable, cfg_we, div_cfg, trim,
        output pll_reset, div, lock, sel_pll, timeout, state
    );

endinterface

// File: rtl/trim_window_monitor.sv
// -----------------------------------------------------------------------------
// trim_window_monitor
// Synchronizes the trim code, qualifies samples by stability, and tracks the
// popcount spread over fixed-length windows.
//   clock, reset  : reference clock, async active-high reset
//   clear_i       : holds the window at its start (min/max/position reset)
//   trim_i        : raw trim code from the PLL domain
//   win_end_o     : high during the last cycle of a window
//   win_good_o    : high with win_end_o when the window had at least one
//                   valid sample and max-min popcount <= TOL
// A sample is valid when the synced code equals the previous synced code,
// which rejects codes caught mid-transition by the synchronizer.
// -----------------------------------------------------------------------------
module trim_window_monitor
    import pll_seq_pkg::*;
#(
    parameter int WIN_CYC = DEF_WIN_CYC,
    parameter int TOL     = DEF_TOL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic [TRIM_W-1:0] trim_i,
    output logic              win_end_o,
    output logic              win_good_o
);

    localparam int              POS_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIN_CYC - 1);
    localparam logic [PC_W-1:0]  TOL_PC   = PC_W'(TOL);
    localparam logic [PC_W-1:0]  MIN_INIT = '1;

    logic [TRIM_W-1:0] sync1_q, sync2_q, prev_q;
    logic [PC_W-1:0]   min_q, min_d, max_q, max_d;
    logic              seen_q, seen_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              samp_vld;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   win_min, win_max;
    logic              win_seen;

    function automatic logic [PC_W-1:0] popcount(input logic [TRIM_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Stage: 2-flop synchronizer plus previous-value register for the stability compare
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= trim_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Current-cycle sample is folded into min/max before the window decision,
    // so the last cycle of a window still counts.
    always_comb begin
        samp_vld = (sync2_q == prev_q);
        pc       = popcount(sync2_q);
        win_min  = min_q;
        win_max  = max_q;
        win_seen = seen_q;
        if (samp_vld) begin
            if (pc < min_q) win_min = pc;
            if (pc > max_q) win_max = pc;
            win_seen = 1'b1;
        end

        win_end_o  = !clear_i && (pos_q == POS_LAST);
        win_good_o = win_end_o && win_seen && ((win_max - win_min) <= TOL_PC);

        if (clear_i || win_end_o) begin
            pos_d  = '0;
            min_d  = MIN_INIT;
            max_d  = '0;
            seen_d = 1'b0;
        end else begin
            pos_d  = pos_q + POS_W'(1);
            min_d  = win_min;
            max_d  = win_max;
            seen_d = win_seen;
        end
    end

    // Stage: window tracker state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_q  <= '0;
            min_q  <= MIN_INIT;
            max_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            min_q  <= min_d;
            max_q  <= max_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
// Reference-clock sequencer for the digital PLL trim loop: resets the PLL
// controller, waits for it to settle, then declares lock after LOCK_WINS
// consecutive good trim windows and requests the clock switch. Flags a sticky
// timeout if lock is not reached within TIMEOUT_WINS windows.
//   clock, reset       : reference clock, async active-high reset
//   seq_if (slave)     : enable, cfg_we, div_cfg, trim in;
//                        pll_reset, div, lock, sel_pll, timeout, state out
// All outputs are registered; they are computed from the next state so they
// change on the same edge as the FSM.
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYC      = DEF_RST_CYC,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int WIN_CYC      = DEF_WIN_CYC,
    parameter int LOCK_WINS    = DEF_LOCK_WINS,
    parameter int TOL          = DEF_TOL,
    parameter int TIMEOUT_WINS = DEF_TIMEOUT_WINS
) (
    input logic                  clock,
    input logic                  reset,
    pll_lock_sequencer_if.slave  seq_if
);

    localparam int CYC_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int GOOD_W  = $clog2(LOCK_WINS + 1);
    localparam int WINC_W  = $clog2(TIMEOUT_WINS + 1);

    localparam logic [CYC_W-1:0]  RST_LAST    = CYC_W'(RST_CYC - 1);
    localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
    localparam logic [GOOD_W-1:0] LOCK_TGT    = GOOD_W'(LOCK_WINS);
    localparam logic [WINC_W-1:0] TO_TGT      = WINC_W'(TIMEOUT_WINS);

    pll_seq_state_t    state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [WINC_W-1:0] winc_q, winc_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              pll_reset_q, pll_reset_d;
    logic              lock_q, lock_d;
    logic              sel_q, sel_d;
    logic              timeout_q, timeout_d;
    logic              restart;
    logic              mon_clear, win_end, win_good;

    function automatic logic [WINC_W-1:0] winc_sat_inc(input logic [WINC_W-1:0] v);
        return (v == TO_TGT) ? v : v + WINC_W'(1);
    endfunction

    // The window only runs while measuring or locked; elsewhere it is held at
    // its start so the first MEASURE cycle opens a fresh window.
    assign mon_clear = !((state_q == ST_MEASURE) || (state_q == ST_LOCKED));

    trim_window_monitor #(
        .WIN_CYC (WIN_CYC),
        .TOL     (TOL)
    ) u_mon (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (mon_clear),
        .trim_i     (seq_if.trim),
        .win_end_o  (win_end),
        .win_good_o (win_good)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = '0;
        good_d  = good_q;
        winc_d  = winc_q;
        div_d   = div_q;
        restart = 1'b0;

        if (seq_if.cfg_we) div_d = clamp_div(seq_if.div_cfg);

        case (state_q)
            ST_IDLE: begin
                if (seq_if.enable) state_d = ST_RSTPLL;
            end
            ST_RSTPLL: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == RST_LAST) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cyc_d  = cyc_q + CYC_W'(1);
                good_d = '0;
                winc_d = '0;
                if (cyc_q == SETTLE_LAST) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (win_end) begin
                    good_d = win_good ? good_q + GOOD_W'(1) : '0;
                    winc_d = winc_sat_inc(winc_q);
                    // Lock wins over timeout when both land on the same window.
                    if (good_d == LOCK_TGT)    state_d = ST_LOCKED;
                    else if (winc_d == TO_TGT) state_d = ST_FAULT;
                end
            end
            ST_LOCKED: begin
                if (win_end && !win_good) begin
                    state_d = ST_MEASURE;
                    good_d  = '0;
                    winc_d  = '0;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A divider change invalidates any lock in progress; IDLE and FAULT
        // only take the new value.
        if (seq_if.cfg_we && (state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
            state_d = ST_RSTPLL;
            restart = 1'b1;
        end

        if (!seq_if.enable) begin
            state_d = ST_IDLE;
            good_d  = '0;
            winc_d  = '0;
        end

        if ((state_d != state_q) || restart) cyc_d = '0;

        pll_reset_d = (state_d == ST_IDLE) || (state_d == ST_RSTPLL) || (state_d == ST_FAULT);
        lock_d      = (state_d == ST_LOCKED);
        sel_d       = lock_d && lock_q;
        timeout_d   = (state_d == ST_FAULT);
    end

    // Stage: FSM, counters and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            good_q      <= '0;
            winc_q      <= '0;
            div_q       <= DIV_RESET;
            pll_reset_q <= 1'b1;
            lock_q      <= 1'b0;
            sel_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            good_q      <= good_d;
            winc_q      <= winc_d;
            div_q       <= div_d;
            pll_reset_q <= pll_reset_d;
            lock_q      <= lock_d;
            sel_q       <= sel_d;
            timeout_q   <= timeout_d;
        end
    end

    assign seq_if.pll_reset = pll_reset_q;
    assign seq_if.div       = div_q;
    assign seq_if.lock      = lock_q;
    assign seq_if.sel_pll   = sel_q;
    assign seq_if.timeout   = timeout_q;
    assign seq_if.state     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Directed scenarios with hand-computed expectations, followed by a randomized
// run, with every cycle compared against a behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RST      = 16;
    localparam int SETTLE   = 1024;
    localparam int WIN      = 256;
    localparam int LOCKW    = 4;
    localparam int TOLV     = 1;
    localparam int TOW      = 64;
    localparam int LOCK_LAT = 1 + RST + SETTLE + LOCKW * WIN;   // 2065
    localparam int TO_LAT   = 1 + RST + SETTLE + TOW * WIN;     // 17425

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pll_lock_sequencer_if dif();

    pll_lock_sequencer #(
        .RST_CYC      (RST),
        .SETTLE_CYC   (SETTLE),
        .WIN_CYC      (WIN),
        .LOCK_WINS    (LOCKW),
        .TOL          (TOLV),
        .TIMEOUT_WINS (TOW)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .seq_if (dif)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic logic [25:0] pat(input int p, input int rot);
        logic [25:0] b;
        b = 26'((64'd1 << p) - 64'd1);
        return (b << rot) | (b >> (26 - rot));
    endfunction

    // ---------------- behavioural model ----------------
    // m_st uses the documented state numbering of the debug output.
    int          m_st = 0, m_rem = 0, m_gc = 0, m_wc = 0, m_wpos = 0, m_lock_age = 0;
    int          m_div = 8;
    logic [25:0] h1 = '0, h2 = '0, h3 = '0;   // trim seen 1, 2, 3 edges ago
    int          win_q[$];

    task automatic model_reset();
        m_st = 0; m_rem = 0; m_gc = 0; m_wc = 0; m_wpos = 0; m_lock_age = 0;
        m_div = 8; h1 = '0; h2 = '0; h3 = '0;
        win_q.delete();
    endtask

    task automatic model_step();
        bit wend, wgood;
        int mn, mx;
        wend = 0; wgood = 0;
        if (m_st == 3 || m_st == 4) begin
            if (h2 == h3) win_q.push_back($countones(h2));
            m_wpos++;
            if (m_wpos == WIN) begin
                wend = 1;
                if (win_q.size() > 0) begin
                    mn = 99; mx = -1;
                    foreach (win_q[i]) begin
                        if (win_q[i] < mn) mn = win_q[i];
                        if (win_q[i] > mx) mx = win_q[i];
                    end
                    wgood = ((mx - mn) <= TOLV);
                end
                win_q.delete();
                m_wpos = 0;
            end
        end else begin
            win_q.delete();
            m_wpos = 0;
        end
        h3 = h2; h2 = h1; h1 = dif.trim;

        if (dif.cfg_we) m_div = (dif.div_cfg < 2) ? 2 : int'(dif.div_cfg);

        if (!dif.enable) begin
            m_st = 0; m_gc = 0; m_wc = 0;
        end else if (dif.cfg_we && m_st != 0 && m_st != 5) begin
            m_st = 1; m_rem = RST;
        end else begin
            case (m_st)
                0: begin m_st = 1; m_rem = RST; end
                1: begin m_rem--; if (m_rem == 0) begin m_st = 2; m_rem = SETTLE; end end
                2: begin m_gc = 0; m_wc = 0; m_rem--; if (m_rem == 0) m_st = 3; end
                3: if (wend) begin
                       m_gc = wgood ? m_gc + 1 : 0;
                       if (m_wc < TOW) m_wc++;
                       if (m_gc >= LOCKW) m_st = 4;
                       else if (m_wc >= TOW) m_st = 5;
                   end
                4: if (wend && !wgood) begin m_st = 3; m_gc = 0; m_wc = 0; end
                default: ;
            endcase
        end
        if (m_st == 4) m_lock_age++; else m_lock_age = 0;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("cmp_state",     int'(dif.state),     m_st);
            check("cmp_pll_reset", int'(dif.pll_reset), (m_st == 0 || m_st == 1 || m_st == 5) ? 1 : 0);
            check("cmp_div",       int'(dif.div),       m_div);
            check("cmp_lock",      int'(dif.lock),      (m_st == 4) ? 1 : 0);
            check("cmp_sel_pll",   int'(dif.sel_pll),   (m_lock_age >= 2) ? 1 : 0);
            check("cmp_timeout",   int'(dif.timeout),   (m_st == 5) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic step_n(input int k);
        repeat (k) step();
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_state"},     int'(dif.state),     0);
        check({tag, "_pll_reset"}, int'(dif.pll_reset), 1);
        check({tag, "_div"},       int'(dif.div),       8);
        check({tag, "_lock"},      int'(dif.lock),      0);
        check({tag, "_sel_pll"},   int'(dif.sel_pll),   0);
        check({tag, "_timeout"},   int'(dif.timeout),   0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, burst, off, r;
        bit seen_lock;
        logic [25:0] cur;

        dif.enable  = 1'b0;
        dif.cfg_we  = 1'b0;
        dif.div_cfg = '0;
        dif.trim    = pat(13, 0);

        step_n(3);
        check_outputs_reset("rst");
        reset  = 1'b0;
        chk_en = 1'b1;
        step_n(4);

        // Steady popcount 13: exact lock latency, sel_pll one cycle later.
        dif.enable = 1'b1;
        n = 0;
        do begin step(); n++; end while (!dif.lock && n < 3000);
        check("lock_latency", n, LOCK_LAT);
        check("sel_at_lock", int'(dif.sel_pll), 0);
        step();
        check("sel_next", int'(dif.sel_pll), 1);

        // Single +2 then -2 excursion mid-window: drop at window end, relock after 4 windows.
        for (int d = 0; d < 2; d++) begin
            step_n(99);
            dif.trim = (d == 0) ? pat(15, 0) : pat(11, 0);
            step_n(4);
            dif.trim = pat(13, 0);
            n = 0;
            do begin step(); n++; end while (dif.lock && n < 400);
            check("drop_edge", n, 152);
            check("drop_sel", int'(dif.sel_pll), 0);
            check("drop_state", int'(dif.state), 3);
            n = 0;
            do begin step(); n++; end while (!dif.lock && n < 2000);
            check("relock_latency", n, LOCKW * WIN);
            step();
            check("relock_sel", int'(dif.sel_pll), 1);
        end

        // Divider change while locked restarts the sequence.
        dif.cfg_we  = 1'b1;
        dif.div_cfg = 5'd12;
        step();
        dif.cfg_we = 1'b0;
        check("cfg_div", int'(dif.div), 12);
        check("cfg_lock", int'(dif.lock), 0);
        check("cfg_state", int'(dif.state), 1);
        n = 1;
        while (n < 40) begin
            step();
            if (dif.pll_reset) n++; else break;
        end
        check("cfg_rst_len", n, RST);
        dif.cfg_we  = 1'b1;
        dif.div_cfg = 5'd1;
        step();
        dif.cfg_we = 1'b0;
        check("cfg_clamp", int'(dif.div), 2);
        check("cfg_restart", int'(dif.state), 1);

        // enable dropped mid-SETTLE.
        step_n(30);
        check("settle_state", int'(dif.state), 2);
        dif.enable = 1'b0;
        step();
        check("en_settle_state", int'(dif.state), 0);
        check("en_settle_rst", int'(dif.pll_reset), 1);

        // enable dropped mid-LOCKED.
        dif.enable = 1'b1;
        n = 0;
        do begin step(); n++; end while (!dif.lock && n < 3000);
        check("lock_latency2", n, LOCK_LAT);
        step_n(10);
        dif.enable = 1'b0;
        step();
        check("en_lock_state", int'(dif.state), 0);
        check("en_lock_lock", int'(dif.lock), 0);
        check("en_lock_sel", int'(dif.sel_pll), 0);
        check("en_lock_rst", int'(dif.pll_reset), 1);

        // Popcount 10/12 alternation: never locks, timeout after 64 windows.
        dif.enable = 1'b1;
        n = 0; seen_lock = 0;
        do begin
            dif.trim = ((n / 8) % 2 == 1) ? pat(12, 3) : pat(10, 0);
            step(); n++;
            if (dif.lock) seen_lock = 1;
        end while (!dif.timeout && n < 20000);
        check("timeout_latency", n, TO_LAT);
        check("timeout_no_lock", int'(seen_lock), 0);
        check("fault_rst", int'(dif.pll_reset), 1);
        step_n(20);
        dif.cfg_we  = 1'b1;
        dif.div_cfg = 5'd20;
        step();
        dif.cfg_we = 1'b0;
        check("fault_cfg_state", int'(dif.state), 5);
        check("fault_cfg_div", int'(dif.div), 20);
        check("fault_sticky", int'(dif.timeout), 1);
        dif.enable = 1'b0;
        step();
        check("fault_exit_timeout", int'(dif.timeout), 0);
        check("fault_exit_state", int'(dif.state), 0);

        // Trim changing every cycle at constant popcount: no valid samples.
        dif.enable = 1'b1;
        seen_lock = 0;
        for (int k = 0; k < 1 + RST + SETTLE + 6 * WIN; k++) begin
            dif.trim = pat(13, k % 26);
            step();
            if (dif.lock) seen_lock = 1;
        end
        check("unstable_no_lock", int'(seen_lock), 0);
        check("unstable_state", int'(dif.state), 3);

        // Asynchronous reset mid-MEASURE.
        #2;
        reset = 1'b1;
        #1;
        check_outputs_reset("async_rst");
        step_n(2);
        reset = 1'b0;
        dif.trim = pat(13, 0);

        // Randomized run.
        cur = pat(13, 0); burst = 0; off = 0;
        for (int k = 0; k < 20000; k++) begin
            r = $urandom_range(0, 999);
            if (r < 4)      cur = pat(13, $urandom_range(0, 25));
            else if (r < 6) cur = pat(14, $urandom_range(0, 25));
            else if (r < 7) cur = pat(12, $urandom_range(0, 25));
            else if (r < 8) cur = pat($urandom_range(10, 16), $urandom_range(0, 25));
            if (burst > 0) begin
                dif.trim = 26'($urandom);
                burst--;
            end else begin
                dif.trim = cur;
                if ($urandom_range(0, 2999) == 0) burst = $urandom_range(1, 20);
            end
            dif.cfg_we  = ($urandom_range(0, 3999) == 0);
            dif.div_cfg = 5'($urandom_range(0, 31));
            if (off > 0) begin
                dif.enable = 1'b0;
                off--;
            end else begin
                dif.enable = 1'b1;
                if ($urandom_range(0, 5999) == 0) off = $urandom_range(1, 30);
            end
            step();
        end
        dif.cfg_we = 1'b0;
        step_n(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
